// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the memory-mapped bus controller:
//   - bus command encodings seen on mem_cmd
//   - default addresses of the output registers, input ports and status
//   - the decode target enumeration used by the address decoder
// No ports (package).
// ---------------------------------------------------------------------------
package mmio_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] DEF_OUT_BASE  = 9'h100;
    localparam logic [8:0] DEF_IN_BASE   = 9'h140;
    localparam logic [8:0] DEF_STAT_ADDR = 9'h17F;

    typedef enum logic [2:0] {
        T_RAM  = 3'd0,
        T_OUT  = 3'd1,
        T_IN   = 3'd2,
        T_STAT = 3'd3,
        T_NONE = 3'd4
    } target_t;

endpackage

// File: rtl/mmio_in_sync.sv
// ---------------------------------------------------------------------------
// mmio_in_sync
// One input port: a two-flop synchroniser followed by a change detector with
// a sticky change flag that is cleared by a status read.
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   async_in    in   PORT_W  raw asynchronous input
//   clear       in   1       clear request for the change flag
//   sync_out    out  PORT_W  synchronised value
//   change_flag out  1       sticky flag, set when sync_out changes
// ---------------------------------------------------------------------------
module mmio_in_sync
    import mmio_pkg::*;
#(
    parameter int PORT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PORT_W-1:0] async_in,
    input  logic              clear,
    output logic [PORT_W-1:0] sync_out,
    output logic              change_flag
);

    logic [PORT_W-1:0] meta_q;
    logic [PORT_W-1:0] prev_q;
    logic              changed;

    // Two synchroniser stages, plus a third copy holding last cycle's
    // synchronised value so a change can be spotted by comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_out <= '0;
            prev_q   <= '0;
        end else begin
            meta_q   <= async_in;
            sync_out <= meta_q;
            prev_q   <= sync_out;
        end
    end

    assign changed = (sync_out != prev_q);

    // Sticky flag. A fresh change in the same cycle as a clear request
    // takes priority, so an event is never lost to a status read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_flag <= 1'b0;
        end else if (changed) begin
            change_flag <= 1'b1;
        end else if (clear) begin
            change_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_bus_ctrl
// Memory-mapped bus controller between the cpu memory interface and on-chip
// RAM, output registers, synchronised input ports and a status register.
// All reads complete with a fixed one-cycle latency through a registered path.
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   mem_cmd     in   2               00 none, 01 read, 10 write, 11 none
//   mem_addr    in   ADDR_W          access address
//   write_data  in   DATA_W          write data
//   read_data   out  DATA_W          registered read data
//   read_valid  out  1               pulse, read_data valid this cycle
//   out_port    out  NUM_OUT*PORT_W  output registers, register i in slice i
//   in_port     in   NUM_IN*PORT_W   asynchronous inputs
//   bus_err     out  1               sticky unmapped-access flag
// ---------------------------------------------------------------------------
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = 9,
    parameter int               RAM_AW    = 8,
    parameter int               NUM_OUT   = 2,
    parameter int               NUM_IN    = 2,
    parameter int               PORT_W    = 8,
    parameter logic [ADDR_W-1:0] OUT_BASE  = DEF_OUT_BASE,
    parameter logic [ADDR_W-1:0] IN_BASE   = DEF_IN_BASE,
    parameter logic [ADDR_W-1:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mem_cmd,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic                      read_valid,
    output logic [NUM_OUT*PORT_W-1:0] out_port,
    input  logic [NUM_IN*PORT_W-1:0]  in_port,
    output logic                      bus_err
);

    logic [DATA_W-1:0] ram_mem [0:(1<<RAM_AW)-1];
    logic [DATA_W-1:0] ram_q;

    logic [PORT_W-1:0] out_regs [NUM_OUT];
    logic [PORT_W-1:0] in_sync  [NUM_IN];
    logic [NUM_IN-1:0] change_flags;

    target_t           target;
    logic              out_hit;
    logic              in_hit;
    logic [PORT_W-1:0] out_rd;
    logic [PORT_W-1:0] in_rd;
    logic [NUM_IN:0]   stat_val;
    logic [DATA_W-1:0] rd_next;

    logic              is_read;
    logic              is_write;
    logic              stat_clear;
    logic              err_event;

    logic [DATA_W-1:0] rd_reg;
    logic              rd_sel_ram;

    assign is_read    = (mem_cmd == MREAD);
    assign is_write   = (mem_cmd == MWRITE);
    assign stat_clear = is_read && (target == T_STAT);
    assign err_event  = (is_read || is_write) && (target == T_NONE);
    assign stat_val   = {bus_err, change_flags};

    // Address decode. Each output/input slot is compared individually so
    // the read-back value can be picked with constant indices; the target
    // priority is RAM window, output register, input port, status.
    always_comb begin
        target  = T_NONE;
        out_hit = 1'b0;
        in_hit  = 1'b0;
        out_rd  = '0;
        in_rd   = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mem_addr == ADDR_W'(OUT_BASE + i)) begin
                out_hit = 1'b1;
                out_rd  = out_regs[i];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (mem_addr == ADDR_W'(IN_BASE + i)) begin
                in_hit = 1'b1;
                in_rd  = in_sync[i];
            end
        end
        if (!mem_addr[ADDR_W-1]) begin
            target = T_RAM;
        end else if (out_hit) begin
            target = T_OUT;
        end else if (in_hit) begin
            target = T_IN;
        end else if (mem_addr == STAT_ADDR) begin
            target = T_STAT;
        end
    end

    // Non-RAM read value, zero-extended to the bus width. Unmapped and RAM
    // targets yield zero here; RAM data comes from its own read register.
    always_comb begin
        rd_next = '0;
        case (target)
            T_OUT:   rd_next = DATA_W'(out_rd);
            T_IN:    rd_next = DATA_W'(in_rd);
            T_STAT:  rd_next = DATA_W'(stat_val);
            default: rd_next = '0;
        endcase
    end

    // Single-port RAM with registered read. Contents are deliberately not
    // reset; the read register only updates on a RAM read so it holds its
    // value between reads. A write followed next cycle by a read of the same
    // address naturally returns the new data.
    always_ff @(posedge clk) begin
        if (is_write && (target == T_RAM)) begin
            ram_mem[mem_addr[RAM_AW-1:0]] <= write_data;
        end
        if (is_read && (target == T_RAM)) begin
            ram_q <= ram_mem[mem_addr[RAM_AW-1:0]];
        end
    end

    // Read response path. The request is captured at the edge, valid pulses
    // in the following cycle, and the source selector and captured value
    // only change on a read so read_data holds between reads. Reset drops
    // any pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_valid <= 1'b0;
            rd_reg     <= '0;
            rd_sel_ram <= 1'b0;
        end else begin
            read_valid <= is_read;
            if (is_read) begin
                rd_reg     <= rd_next;
                rd_sel_ram <= (target == T_RAM);
            end
        end
    end

    assign read_data = rd_sel_ram ? ram_q : rd_reg;

    // Output registers load the low PORT_W bits of the write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_regs[i] <= '0;
            end
        end else if (is_write && (target == T_OUT)) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (mem_addr == ADDR_W'(OUT_BASE + i)) begin
                    out_regs[i] <= write_data[PORT_W-1:0];
                end
            end
        end
    end

    // Flatten the output registers onto the port, register i in slice i.
    always_comb begin
        out_port = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_port[i*PORT_W +: PORT_W] = out_regs[i];
        end
    end

    // Sticky bus error. An unmapped access in the same cycle as a status
    // read wins over the clear so the error is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (err_event) begin
            bus_err <= 1'b1;
        end else if (stat_clear) begin
            bus_err <= 1'b0;
        end
    end

    // One synchroniser and change detector per input port.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        mmio_in_sync #(
            .PORT_W (PORT_W)
        ) u_sync (
            .clk         (clk),
            .reset       (reset),
            .async_in    (in_port[g*PORT_W +: PORT_W]),
            .clear       (stat_clear),
            .sync_out    (in_sync[g]),
            .change_flag (change_flags[g])
        );
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_ctrl
// Directed testbench for mmio_bus_ctrl with hand-computed expected values.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mmio_bus_ctrl;
    import mmio_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_valid;
    logic [15:0] out_port;
    logic [15:0] in_port;
    logic        bus_err;

    int checks;
    int errors;

    mmio_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .out_port   (out_port),
        .in_port    (in_port),
        .bus_err    (bus_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one bus command and advance through one rising edge, returning
    // at the next falling edge where that edge's results are visible.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        @(negedge clk);
    endtask

    // Main directed sequence.
    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        in_port    = '0;
        @(negedge clk);
        @(negedge clk);

        checkOutput("reset_read_data",  32'(read_data),  32'h0);
        checkOutput("reset_read_valid", 32'(read_valid), 32'h0);
        checkOutput("reset_out_port",   32'(out_port),   32'h0);
        checkOutput("reset_bus_err",    32'(bus_err),    32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] output registers");
        applyStimulus(MWRITE, 9'h100, 16'h00A5);
        checkOutput("out0_write", 32'(out_port), 32'h00A5);
        applyStimulus(MWRITE, 9'h101, 16'hFF5A);
        checkOutput("out1_write", 32'(out_port), 32'h5AA5);
        applyStimulus(MREAD, 9'h100, 16'h0);
        checkOutput("out0_rd_valid", 32'(read_valid), 32'h1);
        checkOutput("out0_rd_data",  32'(read_data),  32'h00A5);
        applyStimulus(MREAD, 9'h101, 16'h0);
        checkOutput("out1_rd_data",  32'(read_data),  32'h005A);
        applyStimulus(2'b11, 9'h100, 16'h00FF);
        checkOutput("rsv_no_valid",  32'(read_valid), 32'h0);
        checkOutput("rsv_no_write",  32'(out_port),   32'h5AA5);
        checkOutput("rsv_hold_data", 32'(read_data),  32'h005A);

        $display("[TB] RAM");
        applyStimulus(MWRITE, 9'h010, 16'h1234);
        checkOutput("ram_wr_no_valid", 32'(read_valid), 32'h0);
        applyStimulus(MREAD, 9'h010, 16'h0);
        checkOutput("ram_raw_valid", 32'(read_valid), 32'h1);
        checkOutput("ram_raw_data",  32'(read_data),  32'h1234);
        applyStimulus(MWRITE, 9'h011, 16'hBEEF);
        applyStimulus(MWRITE, 9'h020, 16'hCAFE);
        applyStimulus(MREAD, 9'h010, 16'h0);
        checkOutput("b2b_first_valid", 32'(read_valid), 32'h1);
        checkOutput("b2b_first_data",  32'(read_data),  32'h1234);
        applyStimulus(MREAD, 9'h011, 16'h0);
        checkOutput("b2b_second_valid", 32'(read_valid), 32'h1);
        checkOutput("b2b_second_data",  32'(read_data),  32'hBEEF);
        applyStimulus(MNONE, 9'h0, 16'h0);
        checkOutput("b2b_idle_valid", 32'(read_valid), 32'h0);
        checkOutput("b2b_idle_hold",  32'(read_data),  32'hBEEF);

        $display("[TB] input ports");
        in_port = 16'h003C;
        repeat (4) applyStimulus(MNONE, 9'h0, 16'h0);
        applyStimulus(MREAD, 9'h140, 16'h0);
        checkOutput("in0_rd_data", 32'(read_data), 32'h003C);
        applyStimulus(MREAD, 9'h141, 16'h0);
        checkOutput("in1_rd_data", 32'(read_data), 32'h0000);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("stat_flag0", 32'(read_data), 32'h0001);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("stat_cleared", 32'(read_data), 32'h0000);

        $display("[TB] unmapped access");
        applyStimulus(MREAD, 9'h1F0, 16'h0);
        checkOutput("unmapped_rd_valid", 32'(read_valid), 32'h1);
        checkOutput("unmapped_rd_data",  32'(read_data),  32'h0000);
        checkOutput("unmapped_rd_err",   32'(bus_err),    32'h1);
        applyStimulus(MWRITE, 9'h1F0, 16'h7777);
        checkOutput("unmapped_wr_err",  32'(bus_err),  32'h1);
        checkOutput("unmapped_wr_outs", 32'(out_port), 32'h5AA5);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("stat_err_bit",     32'(read_data), 32'h0004);
        checkOutput("stat_err_cleared", 32'(bus_err),   32'h0);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("stat_err_again", 32'(read_data), 32'h0000);

        $display("[TB] change during status read");
        in_port = 16'h00C3;
        applyStimulus(MNONE, 9'h0, 16'h0);
        applyStimulus(MNONE, 9'h0, 16'h0);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("race_stat_old", 32'(read_data), 32'h0000);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("race_flag_kept", 32'(read_data), 32'h0001);
        applyStimulus(MREAD, 9'h17F, 16'h0);
        checkOutput("race_flag_clr", 32'(read_data), 32'h0000);

        $display("[TB] asynchronous reset mid-read");
        mem_cmd  = MREAD;
        mem_addr = 9'h100;
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", 32'(read_valid), 32'h1);
        reset   = 1'b1;
        mem_cmd = MNONE;
        #1;
        checkOutput("async_rst_valid",   32'(read_valid), 32'h0);
        checkOutput("async_rst_outport", 32'(out_port),   32'h0);
        checkOutput("async_rst_data",    32'(read_data),  32'h0);
        @(negedge clk);
        checkOutput("rst_held_valid", 32'(read_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(MREAD, 9'h020, 16'h0);
        checkOutput("ram_after_rst_valid", 32'(read_valid), 32'h1);
        checkOutput("ram_after_rst_data",  32'(read_data),  32'hCAFE);
        applyStimulus(MNONE, 9'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Memory-mapped bus controller between the cpu memory interface (mem_cmd/mem_addr/write_data/read_data) and on-chip RAM plus parametrised I/O.
Decodes every access to one of four targets: the RAM window, NUM_OUT output registers, NUM_IN synchronised input ports, or a status register.
All reads return through one registered read path with fixed latency.
Input ports have change detection with sticky, read-to-clear flags.

Parameters:
DATA_W, 16, bus data width
ADDR_W, 9, mem_addr width; RAM window is addresses with mem_addr[ADDR_W-1]==0
RAM_AW, 8, RAM address bits (depth 2**RAM_AW); must be <= ADDR_W-1
NUM_OUT, 2, number of output registers (1..16)
NUM_IN, 2, number of input ports (1..16)
PORT_W, 8, width of each I/O port (<= DATA_W)
OUT_BASE, 9'h100, address of output register 0; register i is at OUT_BASE+i
IN_BASE, 9'h140, address of input port 0; port i is at IN_BASE+i
STAT_ADDR, 9'h17F, address of the status register

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_cmd  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
mem_addr  in  ADDR_W  access address
write_data  in  DATA_W  write data
read_data  out  DATA_W  registered read data
read_valid  out  1  one-cycle pulse; read_data is valid in that cycle
out_port  out  NUM_OUT*PORT_W  output register contents, register i in slice i
in_port  in  NUM_IN*PORT_W  asynchronous inputs (switches etc.)
bus_err  out  1  sticky flag: access to an unmapped address

Behaviour:
- Reset (asynchronous) clears: read_data=0, read_valid=0, all out_port registers=0, synchroniser flops=0, change flags=0, bus_err=0. RAM contents are not reset.
- Decode is combinational on mem_addr. Priority order: RAM window (MSB=0), then output register, then input port, then STAT_ADDR, then unmapped.
- Write (mem_cmd=10), effective at the clock edge:
  - RAM: writes mem[mem_addr[RAM_AW-1:0]].
  - Output register i: loads write_data[PORT_W-1:0].
  - Input port or status register: ignored.
  - Unmapped address: sets bus_err.
- Read (mem_cmd=01), latency 1:
  - At edge T the request is captured. In cycle T+1, read_valid=1 and read_data holds the result.
  - RAM reads use a registered RAM read at edge T.
  - Output register returns its current value, zero-extended.
  - Input port returns its synchronised value, zero-extended.
  - STAT_ADDR returns {bus_err, change flags[NUM_IN-1:0]} right-aligned; change flag i is bit i and bus_err is bit NUM_IN.
  - Unmapped address returns 0 and sets bus_err.
  - read_data holds its value when no read is in progress; read_valid=0 in those cycles.
- Back-to-back reads are supported: one per cycle, each valid exactly 1 cycle later.
- Read and write to the same RAM address in one command stream: a read issued the cycle after a write returns the new data. No same-cycle read/write is possible, because mem_cmd is single-valued.
- Input synchronisation:
  - Two flops per port.
  - Change flag i sets when the synchronised value differs from its previous-cycle value.
- Status register read clears all change flags and bus_err at edge T. If a new change or error event occurs in that same cycle, that set wins and the flag stays 1.
- Reset asserted mid-read: read_valid stays 0 and the pending read is discarded.

Decomposition:
- Shared package mmio_pkg holds:
  - MNONE/MREAD/MWRITE command constants
  - default base addresses OUT_BASE, IN_BASE, STAT_ADDR
  - an enum for the decode target {T_RAM, T_OUT, T_IN, T_STAT, T_NONE}
- One natural sub-module: mmio_in_sync, holding the per-port 2-flop synchroniser plus change detector, instantiated NUM_IN times.
- RAM is a separate existing-style single-port registered-read array inside this block.

Test Plan:
1. Reset, then write 16'h00A5 to 9'h100 -> out_port[7:0]=8'hA5 after the edge; read 9'h100 -> next cycle read_valid=1, read_data=16'h00A5.
2. Write 16'h1234 to RAM 9'h010, then read 9'h010 the next cycle -> read_data=16'h1234 one cycle later; reads of 9'h010 and 9'h011 back-to-back -> two consecutive valid pulses in order.
3. Set in_port[7:0]=8'h3C -> read 9'h140 three or more cycles later returns 16'h003C; status read returns bit0=1; a second status read returns 0.
4. Read unmapped 9'h1F0 -> read_data=0, bus_err=1; write unmapped -> bus_err stays 1; status read returns bit NUM_IN=1 then clears.
5. Toggle in_port during the status-read cycle -> the flag remains 1 after the clear.
6. Assert reset asynchronously mid-read and between clock edges -> out_port=0, read_valid=0 immediately; the RAM value written earlier is still readable after reset is released.
